// File: rtl/nn_pkg.sv
// Shared definitions for the 784-30-10 network: layer sequencer states,
// layer sizes and a sizing helper for the latency timer.
package nn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ACCUM,
        DRAIN,
        SQUASH,
        DONE
    } layer_state_t;

    localparam int N_IN  = 784;
    localparam int N_HID = 30;
    localparam int N_OUT = 10;

    // Width holding max(a,b)-1, never below one bit.
    function automatic int timer_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/latency_timer.sv
// Loadable down-counter with a zero flag; times the DRAIN and SQUASH phases.
module latency_timer #(
    parameter int W = 1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_loadVal,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_loadVal;
        else if (i_dec && (r_cnt != '0))
            r_cnt <= r_cnt - W'(1);
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/fc_layer_ctrl.sv
// Fully connected layer sequencer: clear, accumulate, drain, squash, done.
// Optional cycle counter enabled by defining FC_LAYER_CTRL_PERF_EN.
module fc_layer_ctrl
    import nn_pkg::*;
#(
    parameter int NoInputs   = N_IN,
    parameter int MacLatency = 2,
    parameter int SigLatency = 2,
    parameter int AddrWidth  = (NoInputs > 1) ? $clog2(NoInputs) : 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic                 i_hold,
    output logic [AddrWidth-1:0] o_inAddr,
    output logic                 o_macClear,
    output logic                 o_macEn,
    output logic                 o_sigEnable,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [31:0]          o_perfCycles
);

    localparam int TW = timer_width(MacLatency, SigLatency);
    localparam logic [TW-1:0] DrainLd  = TW'((MacLatency > 0) ? MacLatency - 1 : 0);
    localparam logic [TW-1:0] SquashLd = TW'(SigLatency - 1);
    localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(NoInputs - 1);

    layer_state_t         r_state;
    logic [AddrWidth-1:0] r_inAddr;
    logic                 r_macClear, r_macEn, r_sigEnable, r_busy, r_done;

    logic          w_lastStep, w_tLoad, w_tDec, w_tZero;
    logic [TW-1:0] w_tVal;

    // inAddr always shows the next step to consume; macEn marks it consumed.
    assign w_lastStep = (r_state == ACCUM) && r_macEn && (r_inAddr == LastAddr);
    assign w_tLoad    = w_lastStep || ((r_state == DRAIN) && w_tZero);
    assign w_tVal     = ((r_state == DRAIN) || (MacLatency == 0)) ? SquashLd : DrainLd;
    assign w_tDec     = (r_state == DRAIN) || (r_state == SQUASH);

    latency_timer #(.W(TW)) u_timer (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_load    (w_tLoad),
        .i_loadVal (w_tVal),
        .i_dec     (w_tDec),
        .o_zero    (w_tZero)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_inAddr    <= '0;
            r_macClear  <= 1'b0;
            r_macEn     <= 1'b0;
            r_sigEnable <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_macClear  <= 1'b0;
            r_macEn     <= 1'b0;
            r_sigEnable <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                IDLE: if (i_start) begin
                    r_state    <= CLEAR;
                    r_macClear <= 1'b1;
                    r_busy     <= 1'b1;
                end
                CLEAR: begin
                    r_state  <= ACCUM;
                    r_inAddr <= '0;
                    r_macEn  <= ~i_hold;
                end
                ACCUM: begin
                    if (w_lastStep) begin
                        if (MacLatency == 0) begin
                            r_state     <= SQUASH;
                            r_sigEnable <= 1'b1;
                        end else begin
                            r_state <= DRAIN;
                        end
                    end else begin
                        if (r_macEn)
                            r_inAddr <= r_inAddr + AddrWidth'(1);
                        r_macEn <= ~i_hold;
                    end
                end
                DRAIN: if (w_tZero) begin
                    r_state     <= SQUASH;
                    r_sigEnable <= 1'b1;
                end
                SQUASH: begin
                    if (w_tZero) begin
                        r_state  <= DONE;
                        r_done   <= 1'b1;
                        r_inAddr <= '0;
                    end else begin
                        r_sigEnable <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_inAddr    = r_inAddr;
    assign o_macClear  = r_macClear;
    assign o_macEn     = r_macEn;
    assign o_sigEnable = r_sigEnable;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

`ifdef FC_LAYER_CTRL_PERF_EN
    localparam logic [31:0] PerfMax = '1;
    logic [31:0] r_perfCnt, r_perfCycles;

    // Count includes the cycle being entered, so the DONE latch sees the full run.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_perfCnt    <= '0;
            r_perfCycles <= '0;
        end else begin
            if ((r_state == IDLE) && i_start)
                r_perfCnt <= 32'd1;
            else if ((r_state != IDLE) && (r_perfCnt != PerfMax))
                r_perfCnt <= r_perfCnt + 32'd1;
            if ((r_state == SQUASH) && w_tZero)
                r_perfCycles <= (r_perfCnt == PerfMax) ? PerfMax : r_perfCnt + 32'd1;
        end
    end

    assign o_perfCycles = r_perfCycles;
`else
    assign o_perfCycles = '0;
`endif

endmodule

// File: tb/tb_fc_layer_ctrl.sv
// Bench for fc_layer_ctrl: table + random runs against a trace model built
// from the layer timing rules, plus reset, back-to-back and minimal-config sequences.
module tb_fc_layer_ctrl;

    localparam int N  = 4;
    localparam int ML = 2;
    localparam int SL = 2;

    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, hold = 1'b0;
    logic [1:0]  addr;
    logic        clr, en, sig, busy, dn;
    logic [31:0] perf;

    logic        start1 = 1'b0, hold1 = 1'b0;
    logic [0:0]  addr1;
    logic        clr1, en1, sig1, busy1, dn1;
    logic [31:0] perf1;

    fc_layer_ctrl #(.NoInputs(N), .MacLatency(ML), .SigLatency(SL)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_hold(hold),
        .o_inAddr(addr), .o_macClear(clr), .o_macEn(en), .o_sigEnable(sig),
        .o_busy(busy), .o_done(dn), .o_perfCycles(perf)
    );

    fc_layer_ctrl #(.NoInputs(1), .MacLatency(0), .SigLatency(2)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_start(start1), .i_hold(hold1),
        .o_inAddr(addr1), .o_macClear(clr1), .o_macEn(en1), .o_sigEnable(sig1),
        .o_busy(busy1), .o_done(dn1), .o_perfCycles(perf1)
    );

    always #5 clk = ~clk;

    // ctl = {busy, done, macClear, macEn, sigEnable}
    typedef struct {
        logic [1:0] addr;
        bit         chkA;
        logic [4:0] ctl;
    } exp_t;

    typedef struct {
        string       name;
        logic [63:0] hmask;   // hold value sampled at edge e (start edge = 0)
        logic [63:0] smask;   // extra start values sampled at edge e
        int          done_cyc;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    exp_t expq[$];
    int   model_d;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input int a, input bit ca, input logic [4:0] c);
        exp_t r;
        r.addr = 2'(a);
        r.chkA = ca;
        r.ctl  = c;
        return r;
    endfunction

    // Expected per-cycle trace of one run for cycles 1.. (cycle c follows edge c-1).
    task automatic build_model(input logic [63:0] hm);
        int  k, e;
        bit  h, m;
        expq.delete();
        expq.push_back(mk(0, 1'b0, 5'b10100));
        k = 0;
        e = 1;
        while (k < N) begin
            h = (e < 64) ? hm[e] : 1'b0;
            m = ~h;
            expq.push_back(mk(k, 1'b1, {1'b1, 1'b0, 1'b0, m, 1'b0}));
            if (m) k++;
            e++;
        end
        repeat (ML) expq.push_back(mk(0, 1'b0, 5'b10000));
        repeat (SL) expq.push_back(mk(0, 1'b0, 5'b10001));
        expq.push_back(mk(0, 1'b1, 5'b11000));
        model_d = expq.size();
        repeat (3) expq.push_back(mk(0, 1'b1, 5'b00000));
    endtask

    task automatic run(input vec_t v);
        int          dcyc, ndone;
        logic [31:0] perf_at;
        logic [4:0]  ctl;
        build_model(v.hmask);
        dcyc = -1; ndone = 0; perf_at = '0;
        @(negedge clk);
        start = 1'b1;
        hold  = v.hmask[0];
        for (int c = 1; c <= expq.size(); c++) begin
            @(negedge clk);
            start = (c < 64) ? v.smask[c] : 1'b0;
            hold  = (c < 64) ? v.hmask[c] : 1'b0;
            ctl = {busy, dn, clr, en, sig};
            chk($sformatf("%s c%0d ctl", v.name, c), 32'(ctl), 32'(expq[c-1].ctl));
            if (expq[c-1].chkA)
                chk($sformatf("%s c%0d addr", v.name, c), 32'(addr), 32'(expq[c-1].addr));
            if (dn === 1'b1) begin
                ndone++;
                if (dcyc < 0) begin
                    dcyc = c;
                    perf_at = perf;
                end
            end
        end
        start = 1'b0;
        hold  = 1'b0;
        chk({v.name, " ndone"}, 32'(ndone), 32'd1);
        if (v.done_cyc >= 0)
            chk({v.name, " done_cycle"}, 32'(dcyc), 32'(v.done_cyc));
`ifdef FC_LAYER_CTRL_PERF_EN
        chk({v.name, " perf"}, perf_at, 32'(model_d));
`else
        chk({v.name, " perf"}, perf_at, 32'd0);
`endif
    endtask

    vec_t vecs[12];

    initial begin
        int   dcs[$];
        int   nd;
        bit   seen;
        logic [4:0] e1 [6];
        vecs[0] = '{"plain",      64'h0,  64'h0,   10};
        vecs[1] = '{"hold34",     64'hC,  64'h0,   12};
        vecs[2] = '{"hold_clr",   64'h2,  64'h0,   11};
        vecs[3] = '{"hold_drain", 64'hE0, 64'h0,   10};
        vecs[4] = '{"start_ign",  64'h0,  64'h108, 10};
        vecs[5] = '{"start_done", 64'h0,  64'h400, 10};

        // Reset and idle
        repeat (2) @(negedge clk);
        chk("in_reset ctl", 32'({busy, dn, clr, en, sig}), 32'd0);
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk($sformatf("idle c%0d ctl", c), 32'({busy, dn, clr, en, sig}), 32'd0);
            chk($sformatf("idle c%0d addr", c), 32'(addr), 32'd0);
        end
        chk("idle perf", perf, 32'd0);

        for (int i = 0; i < 6; i++) run(vecs[i]);

        for (int i = 6; i < 12; i++) begin
            logic [63:0] hm, sm;
            hm = {$urandom, $urandom} & {$urandom, $urandom};
            build_model(hm);
            sm = '0;
            repeat (3) sm[$urandom_range(model_d, 1)] = 1'b1;
            vecs[i] = '{$sformatf("rnd%0d", i), hm, sm, -1};
            run(vecs[i]);
        end

        // start held high: runs back to back
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (dn === 1'b1) dcs.push_back(c);
        end
        start = 1'b0;
        chk("b2b count", 32'(dcs.size()), 32'd3);
        for (int i = 0; i < dcs.size() && i < 3; i++)
            chk($sformatf("b2b done%0d", i), 32'(dcs[i]), 32'(10 + 11 * i));
        repeat (20) @(negedge clk);
        chk("b2b settle busy", 32'(busy), 32'd0);

        // async reset mid-ACCUM
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 12 && !seen; c++) begin
            @(negedge clk);
            if (addr === 2'd2 && en === 1'b1) seen = 1'b1;
        end
        chk("rst reach_addr2", 32'(seen), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst async ctl", 32'({busy, dn, clr, en, sig}), 32'd0);
        chk("rst async addr", 32'(addr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        nd = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (dn === 1'b1 || busy === 1'b1) nd++;
        end
        chk("rst no_done", 32'(nd), 32'd0);
        vecs[0].name = "after_rst";
        run(vecs[0]);

        // NoInputs=1, MacLatency=0
        e1 = '{5'b10100, 5'b10010, 5'b10001, 5'b10001, 5'b11000, 5'b00000};
        @(negedge clk);
        start1 = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            start1 = 1'b0;
            chk($sformatf("min c%0d ctl", c), 32'({busy1, dn1, clr1, en1, sig1}), 32'(e1[c-1]));
            if (c == 2) chk("min addr", 32'(addr1), 32'd0);
            if (c == 5) begin
`ifdef FC_LAYER_CTRL_PERF_EN
                chk("min perf", perf1, 32'd5);
`else
                chk("min perf", perf1, 32'd0);
`endif
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/fc_layer_ctrl.md
# fc_layer_ctrl

Sequencer for one fully connected layer of the 784-30-10 network. It steps the shared input/weight address through all layer inputs while the parallel per-neuron MAC array accumulates. It then drains the MAC pipeline, enables the bias-add/Sigmoid stage for its latency, and signals completion to the top-level network controller. One instance serves each layer: 784→30 and 30→10.

## Interface
- NoInputs, 784, number of layer inputs; accumulation steps per run (≥1)
- MacLatency, 2, cycles from last macEn to final accumulator value valid (≥0)
- SigLatency, 2, cycles of bias-add register plus Sigmoid stage (≥1)
- AddrWidth, $clog2(NoInputs), width of inAddr (min 1)
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request a layer run; sampled only in IDLE
- hold  in  1  stall accumulation (input source not ready)
- inAddr  out  AddrWidth  input-vector / weight-row address, shared by all neurons
- macClear  out  1  clear all neuron accumulators
- macEn  out  1  accumulate the data at inAddr this cycle
- sigEnable  out  1  enable to bias-add/Sigmoid stage
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse; layer outputs valid
- perfCycles  out  32  cycle count of the last run (see Configuration)

## Operation
- States: IDLE, CLEAR, ACCUM, DRAIN, SQUASH, DONE. All outputs are registered.
- IDLE: all outputs 0, inAddr=0. start=1 → CLEAR.
- CLEAR: macClear=1 for exactly one cycle → ACCUM.
- ACCUM: while hold=0, macEn=1 and inAddr steps by 1 each cycle from 0 to NoInputs-1.
  - hold=1: macEn=0 and inAddr frozen; the step is not consumed.
  - The cycle that presents inAddr=NoInputs-1 with hold=0 is the last ACCUM cycle. Next state is DRAIN, or SQUASH if MacLatency=0.
- DRAIN: MacLatency cycles, all control outputs 0 → SQUASH. hold is ignored.
- SQUASH: sigEnable=1 for SigLatency consecutive cycles → DONE.
- DONE: done=1 for one cycle, busy=1 → IDLE. inAddr returns to 0.
- start outside IDLE is ignored; it is not queued. start held high through DONE begins a new run from the following IDLE cycle.
- A shared down-counter times DRAIN and SQUASH. It is loaded with latency-1 on state entry.
- inAddr never exceeds NoInputs-1, and there is no wrap-around. NoInputs=1 gives a single ACCUM cycle.
- Reset, asynchronous at any time including mid-run: state=IDLE, all outputs 0, counters 0. The partial run is abandoned and no done is issued.

## Timing
- Start sampled at edge 0, hold=0 throughout:
  - CLEAR in cycle 1.
  - ACCUM in cycles 2 .. NoInputs+1.
  - DRAIN in the next MacLatency cycles.
  - SQUASH in the next SigLatency cycles.
  - done in cycle NoInputs+MacLatency+SigLatency+2.
- Defaults: done 790 cycles after the start edge. Each hold cycle in ACCUM adds exactly one cycle.
- inAddr and macEn change together at the same edge. Memory read latency is budgeted inside MacLatency.
- Minimum spacing between successive runs: done cycle + 1 IDLE cycle.

## Configuration
- FC_LAYER_CTRL_PERF_EN defined:
  - A 32-bit counter clears on the CLEAR entry and increments every busy cycle, including DONE.
  - perfCycles latches the count at DONE and holds it until the next DONE. Reset value is 0.
  - Counter saturates at 2^32-1.
- Undefined: no counter logic; perfCycles is tied to 0.

## Structure
- nn_pkg holds the layer_state_t enum (IDLE..DONE) and the layer size constants (784, 30, 10). These are shared with the network top controller and the MAC array.
- One sub-module: latency_timer, a loadable down-counter with a zero flag, used for both DRAIN and SQUASH.
- Perf counter lives inline under the macro.

## Test plan
- Reset release, no start for 20 cycles → busy=done=macEn=0, inAddr=0 throughout.
- NoInputs=4, MacLatency=2, SigLatency=2, start pulse at edge 0:
  - macClear in cycle 1.
  - inAddr 0,1,2,3 with macEn in cycles 2–5.
  - sigEnable in cycles 8–9.
  - done in cycle 10 only.
  - perfCycles=10 when the macro is defined.
- Same config, hold=1 in cycles 3–4 → inAddr stays 1 with macEn=0; done moves to cycle 12.
- start pulsed during ACCUM and during SQUASH → ignored; exactly one done. start held high continuously → back-to-back runs, done every 11 cycles.
- rst asserted asynchronously mid-ACCUM at inAddr=2 → outputs 0 immediately; no done. A fresh start afterwards runs normally with inAddr from 0.
- MacLatency=0, NoInputs=1 → ACCUM one cycle, SQUASH directly after, done in cycle 5.
